// File: rtl/audio_ctrl_pkg.sv
// Shared definitions for the WM8731 audio interface blocks: default sizes,
// frame clock polarity and the transmitter state encoding.
package audio_ctrl_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_FRAME_BCLK = 32;

  // Frame clock level during the left channel half
  localparam logic LRC_LEFT = 1'b1;

  typedef enum logic {
    IDLE,
    RUN
  } tx_state_t;

endpackage

// File: rtl/audio_tx_hold_buf.sv
// One-entry holding register between the upstream valid/ready source and the
// DAC serializer; the serializer drains it with a one-cycle load strobe.
module audio_tx_hold_buf
  import audio_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             bclk,
  input  logic             daclrc,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             load,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data
);

  // A load frees the entry this cycle, so a new sample can replace it at once
  assign s_ready = !hold_valid || load;

  always_ff @(posedge bclk or posedge daclrc) begin
    if (daclrc) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (s_valid && s_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= s_data;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_dac_transmitter.sv
// Left-justified DACDAT serializer for the WM8731: frame counter, IDLE/RUN
// control and MSB-first shifting of each channel, with LRC generated here.
module audio_dac_transmitter
  import audio_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FRAME_BCLK = DEFAULT_FRAME_BCLK
) (
  input  logic             bclk,
  input  logic             daclrc,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             lrc_out,
  output logic             dacdat,
  output logic             frame_start,
  output logic             underflow
);

  localparam int CW = $clog2(FRAME_BCLK);
  localparam logic [CW-1:0] LAST  = CW'(FRAME_BCLK - 1);
  localparam logic [CW-1:0] HALF  = CW'(FRAME_BCLK / 2);
  localparam logic [CW-1:0] HW    = CW'(WIDTH / 2);
  localparam logic [CW-1:0] MSB_L = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_R = CW'(WIDTH / 2 - 1);

  tx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] shift_next;
  logic             load;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  // Bit driven at frame position c; positions past a channel's width are padding
  function automatic logic serial_bit(input logic [WIDTH-1:0] sh, input logic [CW-1:0] c);
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] tmp;
    k   = (c < HALF) ? c : c - HALF;
    tmp = sh >> ((c < HALF) ? MSB_L - k : MSB_R - k);
    serial_bit = (k < HW) ? tmp[0] : 1'b0;
  endfunction

  audio_tx_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .bclk      (bclk),
    .daclrc    (daclrc),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .load      (load),
    .hold_valid(hold_valid),
    .hold_data (hold_data)
  );

  always_comb begin
    load       = 1'b0;
    cnt_next   = '0;
    shift_next = shifter;
    case (state)
      IDLE: begin
        load       = hold_valid;
        shift_next = hold_data;
      end
      RUN: begin
        load     = (cnt == LAST);
        cnt_next = load ? '0 : cnt + 1'b1;
        if (load) shift_next = hold_valid ? hold_data : '0;
      end
      default: ;
    endcase
  end

  // Outputs are computed from the next count/shifter so they align with cnt
  always_ff @(posedge bclk or posedge daclrc) begin
    if (daclrc) begin
      state       <= IDLE;
      cnt         <= '0;
      shifter     <= '0;
      lrc_out     <= 1'b0;
      dacdat      <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_valid) begin
            state       <= RUN;
            cnt         <= '0;
            shifter     <= shift_next;
            lrc_out     <= LRC_LEFT;
            dacdat      <= serial_bit(shift_next, '0);
            frame_start <= 1'b1;
          end
        end
        RUN: begin
          cnt         <= cnt_next;
          shifter     <= shift_next;
          lrc_out     <= (cnt_next < HALF) ? LRC_LEFT : ~LRC_LEFT;
          dacdat      <= serial_bit(shift_next, cnt_next);
          frame_start <= load;
          underflow   <= load && !hold_valid;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_transmitter.sv
// Scoreboard bench: accepted samples queue up with their accept cycle, and a
// codec-style monitor decodes each frame and compares it with the queue.
module tb_audio_dac_transmitter;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } item_t;

  logic        bclk = 1'b0;
  logic        daclrc = 1'b1;
  logic        sel = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;

  logic s_ready32, lrc32, dat32, fs32, uf32;
  logic s_ready40, lrc40, dat40, fs40, uf40;
  logic m_ready, m_lrc, m_dat, m_fs, m_uf;

  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    frames_done = 0;
  int    prev_fs = -1;
  int    last_acc = 0;

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  audio_dac_transmitter #(.WIDTH(32), .FRAME_BCLK(32)) dut32 (
    .bclk(bclk), .daclrc(daclrc), .s_data(s_data), .s_valid(s_valid && !sel),
    .s_ready(s_ready32), .lrc_out(lrc32), .dacdat(dat32),
    .frame_start(fs32), .underflow(uf32)
  );

  audio_dac_transmitter #(.WIDTH(32), .FRAME_BCLK(40)) dut40 (
    .bclk(bclk), .daclrc(daclrc), .s_data(s_data), .s_valid(s_valid && sel),
    .s_ready(s_ready40), .lrc_out(lrc40), .dacdat(dat40),
    .frame_start(fs40), .underflow(uf40)
  );

  assign m_ready = sel ? s_ready40 : s_ready32;
  assign m_lrc   = sel ? lrc40 : lrc32;
  assign m_dat   = sel ? dat40 : dat32;
  assign m_fs    = sel ? fs40 : fs32;
  assign m_uf    = sel ? uf40 : uf32;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, valid left high
  task automatic applyStimulus(input logic [31:0] d);
    int w = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!m_ready && w < 200) begin
      @(negedge bclk);
      w++;
    end
    if (!m_ready) checkOutput("accept_timeout", 64'(m_ready), 64'd1);
    else begin
      q.push_back('{d, cyc + 1});
      last_acc = cyc + 1;
      @(negedge bclk);
    end
  endtask

  task automatic resetDut(input logic use40);
    @(negedge bclk);
    #2;
    daclrc  = 1'b1;
    s_valid = 1'b0;
    q.delete();
    prev_fs = -1;
    sel     = use40;
    repeat (2) @(negedge bclk);
    daclrc = 1'b0;
  endtask

  task automatic waitFrames(input int n);
    int start = frames_done;
    int c = 0;
    while (frames_done < start + n && c < n * 45 + 100) begin
      @(negedge bclk);
      c++;
    end
    checkOutput("frames_timeout", 64'(frames_done >= start + n), 64'd1);
  endtask

  task automatic waitDrain();
    int c = 0;
    while (q.size() > 0 && c < 3000) begin
      @(negedge bclk);
      c++;
    end
    checkOutput("drain_timeout", 64'(q.size()), 64'd0);
    repeat (45) @(negedge bclk);
  endtask

  // Codec model: a sample goes out in the first frame loaded after it was accepted
  initial begin
    logic [63:0] lrc_v, dat_v, exp_lrc;
    logic [31:0] exp_s;
    logic [15:0] left, right;
    logic        exp_u, aborted, fs_extra, pad;
    int          f, h;
    forever begin
      @(negedge bclk);
      if (!daclrc && m_fs) begin
        f = sel ? 40 : 32;
        h = f / 2;
        if (prev_fs >= 0) checkOutput("frame_period", 64'(cyc - prev_fs), 64'(f));
        prev_fs = cyc;
        if (q.size() > 0 && q[0].acc < cyc) begin
          exp_s = q[0].data;
          void'(q.pop_front());
          exp_u = 1'b0;
        end else begin
          exp_s = '0;
          exp_u = 1'b1;
        end
        checkOutput("underflow", 64'(m_uf), 64'(exp_u));
        lrc_v = '0; dat_v = '0; exp_lrc = '0;
        aborted = 1'b0; fs_extra = 1'b0;
        for (int i = 0; i < f; i++) begin
          if (i > 0) begin
            @(negedge bclk);
            if (daclrc) begin
              aborted = 1'b1;
              break;
            end
            if (m_fs) fs_extra = 1'b1;
          end
          lrc_v[i] = m_lrc;
          dat_v[i] = m_dat;
          exp_lrc[i] = (i < h);
        end
        if (!aborted) begin
          pad = 1'b0;
          for (int k = 0; k < 16; k++) begin
            left[15-k]  = dat_v[k];
            right[15-k] = dat_v[h+k];
          end
          for (int k = 16; k < h; k++) pad = pad | dat_v[k] | dat_v[h+k];
          checkOutput("lrc_pattern", lrc_v, exp_lrc);
          checkOutput("decoded_sample", 64'({left, right}), 64'(exp_s));
          checkOutput("padding_zero", 64'(pad), 64'd0);
          checkOutput("single_frame_start", 64'(fs_extra), 64'd0);
          frames_done++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc1, n_fs, n_lrc;
    #12;
    checkOutput("rst_lrc", 64'(lrc32), 64'd0);
    checkOutput("rst_dacdat", 64'(dat32), 64'd0);
    checkOutput("rst_ready", 64'(s_ready32), 64'd1);
    checkOutput("rst_frame_start", 64'(fs32), 64'd0);
    checkOutput("rst_underflow", 64'(uf32), 64'd0);
    resetDut(1'b0);

    $display("[TB] single sample 0xA5A53C3C then underflow");
    applyStimulus(32'hA5A53C3C);
    s_valid = 1'b0;
    checkOutput("idle_lrc", 64'(m_lrc), 64'd0);
    @(negedge bclk);
    checkOutput("first_load_fs", 64'(m_fs), 64'd1);
    checkOutput("first_bit", 64'(m_dat), 64'd1);
    waitFrames(2);

    $display("[TB] back-to-back samples");
    resetDut(1'b0);
    applyStimulus(32'h12345678);
    acc1 = last_acc;
    applyStimulus(32'h9ABCDEF0);
    applyStimulus(32'h0F1E2D3C);
    s_valid = 1'b0;
    checkOutput("third_accept_delay", 64'(last_acc - acc1), 64'd33);
    waitDrain();

    $display("[TB] randomized samples and gaps");
    resetDut(1'b0);
    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = int'($urandom_range(0, 45));
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) @(negedge bclk);
      end
      applyStimulus($urandom);
    end
    s_valid = 1'b0;
    waitDrain();

    $display("[TB] reset mid-frame with a held sample");
    resetDut(1'b0);
    applyStimulus(32'hFFFFFFFF);
    applyStimulus(32'h5A5A5A5A);
    s_valid = 1'b0;
    checkOutput("frame_after_pair", 64'(m_fs), 64'd1);
    repeat (7) @(negedge bclk);
    #2;
    daclrc = 1'b1;
    q.delete();
    prev_fs = -1;
    #1;
    checkOutput("midrst_lrc", 64'(m_lrc), 64'd0);
    checkOutput("midrst_dacdat", 64'(m_dat), 64'd0);
    checkOutput("midrst_ready", 64'(m_ready), 64'd1);
    repeat (2) @(negedge bclk);
    daclrc = 1'b0;
    n_fs = 0;
    n_lrc = 0;
    repeat (40) begin
      @(negedge bclk);
      n_fs += int'(m_fs);
      n_lrc += int'(m_lrc);
    end
    checkOutput("post_rst_idle_fs", 64'(n_fs), 64'd0);
    checkOutput("post_rst_idle_lrc", 64'(n_lrc), 64'd0);
    applyStimulus($urandom);
    s_valid = 1'b0;
    waitDrain();

    $display("[TB] FRAME_BCLK=40 with 0xFFFF0001");
    resetDut(1'b1);
    applyStimulus(32'hFFFF0001);
    s_valid = 1'b0;
    waitFrames(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
